// File: rtl/rx_fifo_sync_if.sv
// Bus between the receive-side producer/consumer and rx_fifo_sync.
// The master drives write/read requests; the slave (the FIFO) returns data and status.
interface rx_fifo_sync_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Handshake: Data_Rdy and Read_Done are level requests sampled at every
  // rising Clk edge (one word per cycle, no ready back-pressure); a request
  // that cannot be honoured is dropped and recorded in a sticky error flag.
  // Data_Valid pulses for one cycle in the cycle after an accepted read.
  logic [DATA_BITS-1:0] Rx_Data;
  logic                 Data_Rdy;
  logic                 Read_Done;
  logic                 Clear_Errors;
  logic [DATA_BITS-1:0] Data_Out;
  logic                 Data_Valid;
  logic                 FIFO_Empty;
  logic                 FIFO_Full;
  logic                 FIFO_Almost_Full;
  logic                 FIFO_Overflow;
  logic                 FIFO_Underflow;
  logic [CW-1:0]        FIFO_Count;

  modport master (
    output Rx_Data, Data_Rdy, Read_Done, Clear_Errors,
    input  Data_Out, Data_Valid, FIFO_Empty, FIFO_Full, FIFO_Almost_Full,
           FIFO_Overflow, FIFO_Underflow, FIFO_Count
  );

  modport slave (
    input  Rx_Data, Data_Rdy, Read_Done, Clear_Errors,
    output Data_Out, Data_Valid, FIFO_Empty, FIFO_Full, FIFO_Almost_Full,
           FIFO_Overflow, FIFO_Underflow, FIFO_Count
  );
endinterface

// File: rtl/rx_fifo_sync.sv
// Synchronous circular-buffer receive FIFO with registered read data,
// registered occupancy flags and sticky overflow/underflow errors.
module rx_fifo_sync #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1
) (
  input logic          Clk,
  input logic          Reset,
  rx_fifo_sync_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count, count_next;
  logic [DATA_BITS-1:0] dout_q;
  logic                 dv_q, empty_q, full_q, af_q, ovf_q, udf_q;
  logic                 wr_acc, rd_acc, ovf_evt, udf_evt;

  // A write into a full FIFO is still accepted when a read frees a slot on the same edge.
  always_comb begin
    rd_acc     = bus.Read_Done && !empty_q;
    wr_acc     = bus.Data_Rdy && (!full_q || rd_acc);
    ovf_evt    = bus.Data_Rdy && !wr_acc;
    udf_evt    = bus.Read_Done && empty_q;
    count_next = count;
    if (wr_acc && !rd_acc)
      count_next = count + CW'(1);
    else if (rd_acc && !wr_acc)
      count_next = count - CW'(1);
  end

  // Storage is not reset; the read pointer never reaches unwritten slots.
  always_ff @(posedge Clk) begin
    if (!Reset && wr_acc)
      mem[wr_ptr] <= bus.Rx_Data;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PW'(1);
        dout_q <= mem[rd_ptr];
      end
      dv_q    <= rd_acc;
      count   <= count_next;
      empty_q <= (count_next == '0);
      full_q  <= (count_next == DEPTH_CNT);
      af_q    <= (count_next >= AF_CNT);
      // A fresh error wins over a simultaneous clear.
      ovf_q   <= ovf_evt || (ovf_q && !bus.Clear_Errors);
      udf_q   <= udf_evt || (udf_q && !bus.Clear_Errors);
    end
  end

  assign bus.Data_Out         = dout_q;
  assign bus.Data_Valid       = dv_q;
  assign bus.FIFO_Empty       = empty_q;
  assign bus.FIFO_Full        = full_q;
  assign bus.FIFO_Almost_Full = af_q;
  assign bus.FIFO_Overflow    = ovf_q;
  assign bus.FIFO_Underflow   = udf_q;
  assign bus.FIFO_Count       = count;
endmodule

// File: doc/rx_fifo_sync.md
RX_FIFO_SYNC -- requirements
Module: rx_fifo_sync

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, receive word width (>=1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of storage words (power of 2, >=2).
REQ-003 SHALL have parameter AF_LEVEL, default FIFO_DEPTH-1, occupancy at or above which FIFO_Almost_Full asserts (1..FIFO_DEPTH).
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 Clk  input  1  sole clock; all state updates on rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 Rx_Data  input  DATA_BITS  word to write.
REQ-008 Data_Rdy  input  1  write request, sampled each Clk edge (level, one word per cycle).
REQ-009 Read_Done  input  1  read request, sampled each Clk edge (level, one word per cycle).
REQ-010 Clear_Errors  input  1  clears sticky error flags.
REQ-011 Data_Out  output  DATA_BITS  registered read data.
REQ-012 Data_Valid  output  1  one-cycle pulse, Data_Out updated this cycle.
REQ-013 FIFO_Empty  output  1  occupancy == 0.
REQ-014 FIFO_Full  output  1  occupancy == FIFO_DEPTH.
REQ-015 FIFO_Almost_Full  output  1  occupancy >= AF_LEVEL.
REQ-016 FIFO_Overflow  output  1  sticky: write attempted while full and not accepted.
REQ-017 FIFO_Underflow  output  1  sticky: read attempted while empty.
REQ-018 FIFO_Count  output  $clog2(FIFO_DEPTH+1)  current occupancy.

Function
REQ-019 SHALL be a circular buffer with write and read pointers of $clog2(FIFO_DEPTH) bits, wrapping FIFO_DEPTH-1 -> 0; no data shifting.
REQ-020 Write accepted when Data_Rdy=1 and (not full, or full with Read_Done=1 accepted same cycle); Rx_Data stored at write pointer, pointer +1.
REQ-021 Read accepted when Read_Done=1 and not empty; word at read pointer loaded into Data_Out on that edge, Data_Valid=1 next cycle only, pointer +1.
REQ-022 Read latency: Data_Out/Data_Valid valid in the cycle after the Read_Done sampling edge; Data_Out holds value until next accepted read.
REQ-023 FIFO_Count: +1 on write-only, -1 on read-only, unchanged on simultaneous accepted write+read or neither.
REQ-024 Status flags SHALL be registered, derived from the updated count, consistent with FIFO_Count in the same cycle.
REQ-025 Full with Data_Rdy=1 and Read_Done=0: write dropped, contents unchanged, FIFO_Overflow set next cycle.
REQ-026 Empty with Read_Done=1: read rejected, Data_Out unchanged, Data_Valid=0, FIFO_Underflow set; a simultaneous Data_Rdy write is still accepted (no fall-through).
REQ-027 Full with Data_Rdy=1 and Read_Done=1: both accepted, oldest word read, new word stored in freed slot, count stays FIFO_DEPTH, no overflow.
REQ-028 Error flags SHALL remain set until Clear_Errors=1 or Reset; if a new error occurs in the same cycle as Clear_Errors, the flag SHALL be set.
REQ-029 No combinational path from any input to any output.

Reset
REQ-030 Reset=1 at a Clk edge SHALL zero both pointers and FIFO_Count, set FIFO_Empty=1, clear FIFO_Full, FIFO_Almost_Full, FIFO_Overflow, FIFO_Underflow, Data_Valid, and set Data_Out=0.
REQ-031 Reset SHALL override Data_Rdy/Read_Done in the same cycle; mid-operation reset discards all stored words.
REQ-032 Storage array contents need not be reset; unread stale words SHALL never appear on Data_Out.

Verification
REQ-033 Reset, write 0x11,0x22,0x33,0x44 (DEPTH=4) -> Count 1..4, Almost_Full at Count=3, Full at 4, Empty=0.
REQ-034 From full, read four times -> Data_Out 0x11,0x22,0x33,0x44 each one cycle after Read_Done with Data_Valid pulse, Empty=1 after fourth.
REQ-035 Full, Data_Rdy=1 with 0x55, Read_Done=0 -> Overflow=1, Count=4, subsequent reads return 0x11..0x44 only; Clear_Errors -> Overflow=0.
REQ-036 Full, Data_Rdy=1 (0x66) and Read_Done=1 same cycle -> Data_Out=0x11, Count=4, Overflow=0; drain ends with 0x66.
REQ-037 Empty, Read_Done=1 and Data_Rdy=1 (0x77) -> Underflow=1, Data_Valid=0, Count=1; next read returns 0x77.
REQ-038 Count=3 with pointers wrapped, assert Reset -> next cycle Count=0, Empty=1, all error flags 0, Data_Out=0.
